mult_div_unit: RTL and testbench

// Iterative multiply/divide unit in the EX stage, alongside the single-cycle ALU, fed the same

---
 rtl/mult_div_unit.sv | 172 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit; results land in HI/LO after WIDTH RUN cycles plus a FIX cycle.
// Define MDU_DIV_EN to build the restoring divider; without it divide ops complete as no-ops.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic               is_div_q;
    logic               neg_res;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               dbz_q;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod;
    logic               early_fix;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic               res_dbz;

    // Signed ops run the unsigned core on magnitudes; the sign is restored in FIX.
    assign a_neg = ~op[0] & a[WIDTH-1];
    assign b_neg = ~op[0] & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};

`ifdef MDU_DIV_EN
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] rem;
    logic             neg_rem;
    logic             zero_div;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ok;

    // The shifted partial remainder is WIDTH+1 bits; the difference fits WIDTH bits whenever it is kept.
    assign div_shift = {rem, acc[WIDTH-1]};
    assign div_ok    = div_shift >= {1'b0, opnd};
    assign div_diff  = div_shift[WIDTH-1:0] - opnd;
    assign early_fix = is_div_q & zero_div;
`else
    assign early_fix = is_div_q;
`endif

    always_comb begin
        prod    = neg_res ? -acc : acc;
        res_hi  = prod[2*WIDTH-1:WIDTH];
        res_lo  = prod[WIDTH-1:0];
        res_dbz = 1'b0;
        if (is_div_q) begin
`ifdef MDU_DIV_EN
            if (zero_div) begin
                res_hi  = a_q;
                res_lo  = '1;
                res_dbz = 1'b1;
            end else begin
                res_lo = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                res_hi = neg_rem ? -rem : rem;
            end
`else
            res_hi = hi_q;
            res_lo = lo_q;
`endif
        end
    end

    assign busy        = (state == S_RUN);
    assign done        = (state == S_FIX);
    assign hi          = done ? res_hi : hi_q;
    assign lo          = done ? res_lo : lo_q;
    assign div_by_zero = done ? res_dbz : dbz_q;

    // FIX commits the corrected result and doubles as an accept slot for back-to-back ops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            is_div_q <= 1'b0;
            neg_res  <= 1'b0;
            opnd     <= '0;
            acc      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
        end else begin
            if (state == S_FIX) begin
                hi_q  <= res_hi;
                lo_q  <= res_lo;
                dbz_q <= res_dbz;
            end
            case (state)
                S_RUN: begin
                    if (early_fix) begin
                        state <= S_FIX;
                    end else begin
                        if (cnt == LAST) state <= S_FIX;
                        cnt <= cnt + 1'b1;
`ifdef MDU_DIV_EN
                        if (is_div_q) acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], div_ok};
                        else          acc <= {mul_sum, acc[WIDTH-1:1]};
`else
                        acc <= {mul_sum, acc[WIDTH-1:1]};
`endif
                    end
                end
                default: begin
                    state <= S_IDLE;
                    if (start) begin
                        state    <= S_RUN;
                        cnt      <= '0;
                        is_div_q <= op[1];
                        neg_res  <= a_neg ^ b_neg;
                        if (op[1]) begin
                            opnd <= b_mag;
                            acc  <= {{WIDTH{1'b0}}, a_mag};
                        end else begin
                            opnd <= a_mag;
                            acc  <= {{WIDTH{1'b0}}, b_mag};
                        end
                    end
                end
            endcase
        end
    end

`ifdef MDU_DIV_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            rem      <= '0;
            neg_rem  <= 1'b0;
            zero_div <= 1'b0;
        end else if (state != S_RUN) begin
            if (start) begin
                a_q      <= a;
                rem      <= '0;
                neg_rem  <= a_neg;
                zero_div <= op[1] && (b == '0);
            end
        end else if (is_div_q && !zero_div) begin
            rem <= div_ok ? div_diff : div_shift[WIDTH-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: arithmetic reference model compared every cycle,
// plus directed operations with hand-computed results. Honors MDU_DIV_EN like the design.
module tb_mult_div_unit;
    localparam int W = 32;
`ifdef MDU_DIV_EN
    localparam bit DIVEN = 1'b1;
`else
    localparam bit DIVEN = 1'b0;
`endif
    localparam int DLAT = DIVEN ? 33 : 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [1:0]    op;
    logic          start;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          div_by_zero;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    int           left = 0;
    bit           accepting;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic         m_busy = 1'b0;
    logic         m_done = 1'b0;
    logic         m_dbz = 1'b0;
    logic [W-1:0] p_hi = '0;
    logic [W-1:0] p_lo = '0;
    logic         p_dbz = 1'b0;
    logic         p_hold = 1'b0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .start(start),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference result straight from integer arithmetic; lat counts edges after accept until done.
    function automatic void modelOp(input logic [1:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                                    output logic [W-1:0] rh, output logic [W-1:0] rl,
                                    output logic rd, output logic hold, output int lat);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa   = mop[0] ? longint'({32'b0, ma}) : longint'($signed(ma));
        sb   = mop[0] ? longint'({32'b0, mb}) : longint'($signed(mb));
        rd   = 1'b0;
        hold = 1'b0;
        lat  = W;
        rh   = '0;
        rl   = '0;
        if (!mop[1]) begin
            p  = sa * sb;
            rh = p[63:32];
            rl = p[31:0];
        end else if (!DIVEN) begin
            hold = 1'b1;
            lat  = 1;
        end else if (mb == '0) begin
            rh  = ma;
            rl  = '1;
            rd  = 1'b1;
            lat = 1;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            rh = r[31:0];
            rl = q[31:0];
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            left   = 0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_hi   = '0;
            m_lo   = '0;
            m_dbz  = 1'b0;
        end else begin
            accepting = start && (left == 0);
            m_done = 1'b0;
            if (left == 1) begin
                m_done = 1'b1;
                if (!p_hold) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                end
                m_dbz = p_dbz;
            end
            if (left > 0) left--;
            if (accepting) modelOp(op, a, b, p_hi, p_lo, p_dbz, p_hold, left);
            m_busy = (left > 0);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("cyc_busy", busy, m_busy);
            checkOutput("cyc_done", done, m_done);
            checkOutput("cyc_hi", hi, m_hi);
            checkOutput("cyc_lo", lo, m_lo);
            checkOutput("cyc_dbz", div_by_zero, m_dbz);
        end
    end

    // Called at a falling edge; the next rising edge samples the request.
    task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input int n0, output int n);
        n = n0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("done_seen", done, 1'b1);
    endtask

    task automatic runOp(input string name, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input int elat, input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed);
        int n;
        applyStimulus(o, x, y);
        waitDone(1, n);
        checkOutput({name, "_lat"}, n, elat);
        checkOutput({name, "_hi"}, hi, eh);
        checkOutput({name, "_lo"}, lo, el);
        checkOutput({name, "_dbz"}, div_by_zero, ed);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int dcount;
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_hi", hi, 32'h0);
        checkOutput("rst_lo", lo, 32'h0);
        checkOutput("rst_dbz", div_by_zero, 1'b0);
        rst = 1'b0;

        runOp("mult_neg", 2'b00, 32'd7, 32'hFFFFFFFD, 33, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        runOp("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        runOp("b2b_mult", 2'b00, 32'h80000000, 32'd2, 33, 32'hFFFFFFFF, 32'h00000000, 1'b0);
        runOp("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, DLAT,
              32'hFFFFFFFF, DIVEN ? 32'hFFFFFFFD : 32'h0, 1'b0);
        runOp("divu", 2'b11, 32'd100, 32'd7, DLAT,
              DIVEN ? 32'd2 : 32'hFFFFFFFF, DIVEN ? 32'd14 : 32'h0, 1'b0);
        runOp("div_min", 2'b10, 32'h80000000, 32'hFFFFFFFF, DLAT,
              DIVEN ? 32'h0 : 32'hFFFFFFFF, DIVEN ? 32'h80000000 : 32'h0, 1'b0);
        runOp("div_negb", 2'b10, 32'd7, 32'hFFFFFFFE, DLAT,
              DIVEN ? 32'd1 : 32'hFFFFFFFF, DIVEN ? 32'hFFFFFFFD : 32'h0, 1'b0);
        runOp("divu_zero", 2'b11, 32'd100, 32'd0, 2,
              DIVEN ? 32'h64 : 32'hFFFFFFFF, DIVEN ? 32'hFFFFFFFF : 32'h0, DIVEN);

        repeat (3) @(negedge clk);
        checkOutput("hold_hi", hi, DIVEN ? 32'h64 : 32'hFFFFFFFF);
        checkOutput("hold_lo", lo, DIVEN ? 32'hFFFFFFFF : 32'h0);
        checkOutput("hold_dbz", div_by_zero, DIVEN);

        runOp("multu_zero", 2'b01, 32'd12345, 32'd0, 33, 32'h0, 32'h0, 1'b0);

        // Different-op requests while busy must not disturb the running multiply.
        applyStimulus(2'b00, 32'd5, 32'd6);
        op    = 2'b11;
        a     = 32'd1;
        b     = 32'd1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        waitDone(4, n);
        checkOutput("ignore_lat", n, 33);
        checkOutput("ignore_hi", hi, 32'h0);
        checkOutput("ignore_lo", lo, 32'd30);

        runOp("mult_m1", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h0, 32'h1, 1'b0);

        applyStimulus(2'b00, 32'd3, 32'd4);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", busy, 1'b0);
        checkOutput("abort_done", done, 1'b0);
        checkOutput("abort_hi", hi, 32'h0);
        checkOutput("abort_lo", lo, 32'h0);
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        checkOutput("abort_nodone", dcount, 0);

        runOp("post_rst", 2'b01, 32'd3, 32'd4, 33, 32'h0, 32'd12, 1'b0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
